mod107_residue_accumulator: RTL and testbench
=============================================

Name: mod107_residue_accumulator

Overview:
- Sequential reduction stage directly downstream of the mod-107 slice LUTs (6-bit input slice -> 7-bit residue).
- Consumes one slice residue per accepted beat and keeps a running sum mod 107.
- Closes a frame after the residue of the last slice of a 400-bit operand (67 slices) and presents the final 7-bit residue with a valid/ready handshake.

Parameters:
MOD, 107, modulus; all accumulated values lie in [0, MOD-1]
RW, 7, residue width; ceil(log2(MOD))
N_TERMS, 67, slices per frame (ceil(400/6))
CW, 7, term counter width; must hold N_TERMS

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous frame abort
in_valid  in  1  in_res is valid this cycle
in_ready  out  1  block accepts a beat this cycle
in_res  in  RW  slice residue from the LUT stage (legal range 0..106)
in_last  in  1  marks the final slice of the frame
out_valid  out  1  out_res and out_err are valid
out_ready  in  1  consumer takes the result
out_res  out  RW  frame residue mod MOD
out_err  out  1  frame error: illegal residue or wrong term count

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, acc=0, cnt=0, err_acc=0.
  - out_res=0, out_valid=0, out_err=0.
  - in_ready goes to 1 once reset is released.
- States: IDLE, ACCUM, DONE. in_ready=1 in IDLE and ACCUM, 0 in DONE. in_ready is combinational from state only.
- Accept: in_valid & in_ready at a rising edge.
- Input sanitise:
  - r = in_res-MOD if in_res >= MOD (result 0..20), else r = in_res.
  - in_res >= MOD sets err_acc.
- Accumulate:
  - base = 0 in IDLE, acc in ACCUM.
  - s = base + r, 8-bit, s <= 212.
  - acc_next = s-MOD if s >= MOD, else s. Exactly one conditional subtract, single cycle.
- Term count: cnt_next = (IDLE ? 1 : cnt+1).
- Frame end occurs on an accepted beat with in_last=1, or with cnt_next == N_TERMS, whichever comes first.
  - out_err = err_acc_next | (cnt_next != N_TERMS) | (cnt_next == N_TERMS & !in_last).
  - out_res = acc_next.
  - out_valid=1 on the next cycle; state=DONE. Latency is 1 cycle from the final accept to out_valid.
- A non-final accept moves IDLE->ACCUM or stays in ACCUM.
- DONE:
  - out_res, out_err and out_valid are held stable until out_valid & out_ready.
  - On that edge: out_valid=0, state=IDLE, acc=0, cnt=0, err_acc=0.
  - in_ready=1 from the following cycle. There is no same-cycle bypass, so there is 1 bubble cycle per frame.
- Inputs presented while in_ready=0 are ignored and do not change state.
- clr=1 at an edge:
  - Forces IDLE, acc=0, cnt=0, err_acc=0, out_valid=0.
  - out_res and out_err keep their last values.
  - clr has priority over accept and over the output handshake.
- Single-term frame (in_last on the first beat): legal only if N_TERMS=1; otherwise out_err=1.
- Reset asserted mid-frame or while in DONE: the result is discarded and all state returns immediately to reset values.

Test Plan:
- 67 beats of in_res=106, in_last on beat 67, out_ready=1 -> out_valid 1 cycle after beat 67; out_res=40, out_err=0; in_ready=0 for exactly that one cycle.
- 67 beats alternating 100,7,100,... (beat 67 = 100), in_last on beat 67 -> out_res=100, out_err=0.
- 67 beats of 0 except beat 10 = 127 -> out_res=20, out_err=1.
- Frame of 2 beats, 50 then 60 with in_last -> out_res=3, out_err=1. Next frame of 67 beats of value 1 -> out_res=67, out_err=0.
- After the result, hold out_ready=0 for 10 cycles while driving in_valid=1, in_res=5 -> out_res/out_err stable, in_ready=0, no beats absorbed. Then pulse out_ready -> out_valid=0 next cycle, in_ready=1.
- Async rst asserted mid-frame after 30 beats -> all outputs 0 immediately. clr after 30 beats -> IDLE. A fresh 67-beat frame of 2s afterwards gives out_res=27 (134-107), out_err=0.

Source files
------------

// File: rtl/mod107_residue_accumulator.sv
// Running mod-107 sum of slice residues; emits one 7-bit frame residue plus an
// error flag per frame (67 slices of a 400-bit operand) over a valid/ready port.
module mod107_residue_accumulator #(
  parameter int MOD     = 107,
  parameter int RW      = 7,
  parameter int N_TERMS = 67,
  parameter int CW      = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_res,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_res,
  output logic          out_err,
  output logic [1:0]    dbg_state
);

  // Handshake: a beat is taken on any rising edge where in_valid & in_ready;
  // the result is taken on any rising edge where out_valid & out_ready.
  // Neither side may drop valid or change data while waiting for ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [RW-1:0] MOD_R   = RW'(MOD);
  localparam logic [RW:0]   MOD_S   = (RW+1)'(MOD);
  localparam logic [CW-1:0] N_TERMS_C = CW'(N_TERMS);

  state_t        state_q;
  logic [RW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic          err_acc_q;
  logic [RW-1:0] out_res_q;
  logic          out_err_q;
  logic          out_valid_q;

  logic          accept;
  logic          in_illegal;
  logic [RW-1:0] r_san;
  logic [RW-1:0] base;
  logic [RW:0]   sum_s;
  logic [RW:0]   sum_sub;
  logic [RW-1:0] acc_d;
  logic [CW-1:0] cnt_d;
  logic          err_acc_d;
  logic          cnt_full;
  logic          frame_end;
  logic          frame_err;

  assign in_ready  = (state_q != DONE);
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_err   = out_err_q;
  assign dbg_state = state_q;

  // Out-of-range LUT outputs (107..127) are folded back into range and flagged.
  always_comb begin
    accept     = in_valid & in_ready;
    in_illegal = (in_res >= MOD_R);
    r_san      = in_illegal ? (in_res - MOD_R) : in_res;
    base       = (state_q == IDLE) ? '0 : acc_q;
    sum_s      = {1'b0, base} + {1'b0, r_san};
    sum_sub    = sum_s - MOD_S;
    acc_d      = (sum_s >= MOD_S) ? sum_sub[RW-1:0] : sum_s[RW-1:0];
    cnt_d      = (state_q == IDLE) ? CW'(1) : (cnt_q + CW'(1));
    err_acc_d  = ((state_q == IDLE) ? 1'b0 : err_acc_q) | in_illegal;
    cnt_full   = (cnt_d == N_TERMS_C);
    frame_end  = in_last | cnt_full;
    frame_err  = err_acc_d | !cnt_full | (cnt_full & !in_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_acc_q   <= 1'b0;
      out_res_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      // Abort drops any pending result but leaves the last out_res/out_err visible.
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_acc_q <= err_acc_d;
            if (frame_end) begin
              state_q     <= DONE;
              out_res_q   <= acc_d;
              out_err_q   <= frame_err;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod107_residue_accumulator.sv
// Bench for mod107_residue_accumulator: directed and random frames, expected
// residues computed arithmetically and queued, then checked when results emerge.
module tb_mod107_residue_accumulator;

  localparam int NT = 67;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_res;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_res;
  logic       out_err;
  logic [1:0] dbg_state;

  logic [7:0] exp_q[$];
  logic [7:0] last_exp;
  int         vals[NT];
  int         n_cmp = 0;
  int         n_err = 0;

  mod107_residue_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge; random bubbles precede each beat.
  task automatic drive_beat(input int v, input bit last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_res   = 7'(v);
    in_last  = last;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int  lat;
    bit  seen;
    seen = 1'b0;
    lat  = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      last_exp = exp_q.pop_front();
      check({tag, "_latency"}, lat, 0);
      check({tag, "_res"}, out_res, last_exp[6:0]);
      check({tag, "_err"}, out_err, last_exp[7]);
      check({tag, "_in_ready_done"}, in_ready, 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input int n);
    int sum;
    int v;
    bit e;
    sum = 0;
    e   = (n != NT);
    for (int i = 0; i < n; i++) begin
      v = vals[i];
      if (v >= 107) begin
        e = 1'b1;
        v = v - 107;
      end
      sum = (sum + v) % 107;
    end
    exp_q.push_back({e, 7'(sum)});
    for (int i = 0; i < n; i++) drive_beat(vals[i], i == n - 1);
    wait_result(tag);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_res = '0; in_last = 1'b0;
    out_ready = 1'b1; last_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_err", out_err, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);

    // All-106 frame: 67*106 mod 107 = 40; in_ready low for exactly one cycle.
    for (int i = 0; i < NT; i++) vals[i] = 106;
    run_frame("max", NT);
    @(negedge clk);
    check("max_in_ready_after", in_ready, 1);
    check("max_out_valid_after", out_valid, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NT; i++) vals[i] = (i % 2 == 0) ? 100 : 7;
    run_frame("alt", NT);

    for (int i = 0; i < NT; i++) vals[i] = 0;
    vals[9] = 127;
    run_frame("illegal", NT);

    vals[0] = 50; vals[1] = 60;
    run_frame("short", 2);

    for (int i = 0; i < NT; i++) vals[i] = 1;
    run_frame("ones", NT);

    for (int k = 0; k < 3; k++) begin
      int n;
      n = (k == 0) ? NT : $urandom_range(1, NT);
      for (int i = 0; i < NT; i++) vals[i] = $urandom_range(0, 127);
      run_frame("rand", n);
    end

    // Back-pressure: result held, inputs ignored while DONE.
    for (int i = 0; i < NT; i++) vals[i] = 3;
    out_ready = 1'b0;
    run_frame("hold", NT);
    in_valid = 1'b1;
    in_res   = 7'd5;
    repeat (10) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_res", out_res, last_exp[6:0]);
      check("hold_out_err", out_err, last_exp[7]);
      check("hold_in_ready", in_ready, 0);
      check("hold_state", dbg_state, 2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_state", dbg_state, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Abort mid-frame with clr: pending sum dropped, last result stays visible.
    for (int i = 0; i < 30; i++) drive_beat(9, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_state", dbg_state, 0);
    check("clr_out_valid", out_valid, 0);
    check("clr_out_res_kept", out_res, 94);
    check("clr_out_err_kept", out_err, 0);

    // clr while a result waits in DONE.
    for (int i = 0; i < NT; i++) vals[i] = 1;
    out_ready = 1'b0;
    run_frame("clr_done", NT);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    out_ready = 1'b1;
    check("clr_done_out_valid", out_valid, 0);
    check("clr_done_state", dbg_state, 0);
    check("clr_done_out_res", out_res, 67);

    // Async reset mid-frame takes effect without a clock edge.
    for (int i = 0; i < 30; i++) drive_beat(9, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_res", out_res, 0);
    check("arst_out_err", out_err, 0);
    check("arst_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NT; i++) vals[i] = 2;
    run_frame("twos", NT);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
